led_pwm_bank: RTL and testbench

//  Multi-channel LED driver fed by the SB_HFOSC clock. Each channel runs a PWM

---
 rtl/led_pwm_pkg.sv | 23 ++
 rtl/led_pwm_timebase.sv | 115 +++++++++++
 rtl/led_pwm_bank.sv | 135 +++++++++++++
 tb/tb_led_pwm_bank.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_pwm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | led_pwm_pkg : mode encodings and width helper for the LED PWM bank     |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
package led_pwm_pkg;

  localparam int MODE_W = 2;

  typedef logic [MODE_W-1:0] mode_t;

  localparam mode_t LED_OFF     = 2'd0;
  localparam mode_t LED_ON      = 2'd1;
  localparam mode_t LED_BLINK   = 2'd2;
  localparam mode_t LED_BREATHE = 2'd3;

  // Counter width able to hold 0..n-1, never less than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_pwm_timebase.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | led_pwm_timebase : prescaler, PWM frame counter, blink and breathe     |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module led_pwm_timebase
  import led_pwm_pkg::*;
#(
  parameter int PWM_W        = 8,
  parameter int PRESC_DIV    = 48,
  parameter int BLINK_FRAMES = 2048,
  parameter int BREATH_STEP  = 16
) (
  input  logic             clk,
  input  logic             rst,
  output logic [PWM_W-1:0] pwm_cnt_o,
  output logic             frame_tick_o,
  output logic             blink_phase_o,
  output logic [PWM_W-1:0] ramp_o
);

  localparam int PRSC_W = cnt_w(PRESC_DIV);
  localparam int BLK_W  = cnt_w(BLINK_FRAMES);
  localparam int BRS_W  = cnt_w(BREATH_STEP);

  localparam logic [PRSC_W-1:0] PRSC_LAST = PRSC_W'(PRESC_DIV - 1);
  localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'(BLINK_FRAMES - 1);
  localparam logic [BRS_W-1:0]  BRS_LAST  = BRS_W'(BREATH_STEP - 1);

  logic [PRSC_W-1:0] prsc_q, prsc_d;
  logic [PWM_W-1:0]  pwm_cnt_q, pwm_cnt_d;
  logic              frame_tick_q, frame_tick_d;
  logic [BLK_W-1:0]  blk_cnt_q, blk_cnt_d;
  logic              blink_q, blink_d;
  logic [BRS_W-1:0]  brs_cnt_q, brs_cnt_d;
  logic [PWM_W-1:0]  ramp_q, ramp_d;
  logic              ramp_dn_q, ramp_dn_d;
  logic              pwm_tick;
  logic              frame_end;
  logic              breath_step;

  // Blink and ramp advance on the frame's last tick, so they are already
  // updated when pwm_cnt wraps to 0 and stay constant over a whole frame.
  always_comb begin
    pwm_tick     = (prsc_q == PRSC_LAST);
    frame_end    = pwm_tick && (pwm_cnt_q == '1);
    prsc_d       = pwm_tick ? '0 : prsc_q + 1'b1;
    pwm_cnt_d    = pwm_tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
    frame_tick_d = frame_end;

    blk_cnt_d = blk_cnt_q;
    blink_d   = blink_q;
    if (frame_end) begin
      if (blk_cnt_q == BLK_LAST) begin
        blk_cnt_d = '0;
        blink_d   = ~blink_q;
      end else begin
        blk_cnt_d = blk_cnt_q + 1'b1;
      end
    end

    brs_cnt_d   = brs_cnt_q;
    breath_step = 1'b0;
    if (frame_end) begin
      if (brs_cnt_q == BRS_LAST) begin
        brs_cnt_d   = '0;
        breath_step = 1'b1;
      end else begin
        brs_cnt_d = brs_cnt_q + 1'b1;
      end
    end

    // Direction flips as an endpoint is reached, so each endpoint lasts one step.
    ramp_d    = ramp_q;
    ramp_dn_d = ramp_dn_q;
    if (breath_step) begin
      if (ramp_dn_q) begin
        ramp_d = ramp_q - 1'b1;
        if (ramp_d == '0) ramp_dn_d = 1'b0;
      end else begin
        ramp_d = ramp_q + 1'b1;
        if (ramp_d == '1) ramp_dn_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prsc_q       <= '0;
      pwm_cnt_q    <= '0;
      frame_tick_q <= 1'b0;
      blk_cnt_q    <= '0;
      blink_q      <= 1'b0;
      brs_cnt_q    <= '0;
      ramp_q       <= '0;
      ramp_dn_q    <= 1'b0;
    end else begin
      prsc_q       <= prsc_d;
      pwm_cnt_q    <= pwm_cnt_d;
      frame_tick_q <= frame_tick_d;
      blk_cnt_q    <= blk_cnt_d;
      blink_q      <= blink_d;
      brs_cnt_q    <= brs_cnt_d;
      ramp_q       <= ramp_d;
      ramp_dn_q    <= ramp_dn_d;
    end
  end

  assign pwm_cnt_o     = pwm_cnt_q;
  assign frame_tick_o  = frame_tick_q;
  assign blink_phase_o = blink_q;
  assign ramp_o        = ramp_q;

endmodule
`default_nettype wire

// File: rtl/led_pwm_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | led_pwm_bank : multi-channel OFF/ON/BLINK/BREATHE LED PWM driver       |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module led_pwm_bank
  import led_pwm_pkg::*;
#(
  parameter int N_CH         = 3,
  parameter int PWM_W        = 8,
  parameter int PRESC_DIV    = 48,
  parameter int BLINK_FRAMES = 2048,
  parameter int BREATH_STEP  = 16,
  localparam int CH_W        = cnt_w(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [MODE_W-1:0] cfg_mode,
  input  logic [PWM_W-1:0]  cfg_duty,
  output logic [N_CH-1:0]   led,
  output logic              frame_tick
);

  logic [PWM_W-1:0] pwm_cnt;
  logic [PWM_W-1:0] ramp;
  logic             tb_frame_tick;
  logic             blink_phase;

  led_pwm_timebase #(
    .PWM_W        (PWM_W),
    .PRESC_DIV    (PRESC_DIV),
    .BLINK_FRAMES (BLINK_FRAMES),
    .BREATH_STEP  (BREATH_STEP)
  ) u_timebase (
    .clk           (clk),
    .rst           (rst),
    .pwm_cnt_o     (pwm_cnt),
    .frame_tick_o  (tb_frame_tick),
    .blink_phase_o (blink_phase),
    .ramp_o        (ramp)
  );

  logic             pend_q, pend_d;
  logic             ready_q, ready_d;
  logic [CH_W-1:0]  pend_ch_q, pend_ch_d;
  mode_t            pend_mode_q, pend_mode_d;
  logic [PWM_W-1:0] pend_duty_q, pend_duty_d;
  logic             accept;
  logic             commit;

  // Single-entry config slot; a slot filled on a frame_tick edge only
  // becomes visible after it, so it waits for the following frame.
  always_comb begin
    accept      = cfg_valid && ready_q;
    commit      = tb_frame_tick && pend_q;
    pend_d      = pend_q;
    pend_ch_d   = pend_ch_q;
    pend_mode_d = pend_mode_q;
    pend_duty_d = pend_duty_q;
    if (accept) begin
      pend_d      = 1'b1;
      pend_ch_d   = cfg_ch;
      pend_mode_d = cfg_mode;
      pend_duty_d = cfg_duty;
    end else if (commit) begin
      pend_d = 1'b0;
    end
    ready_d = ~pend_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q      <= 1'b0;
      ready_q     <= 1'b0;
      pend_ch_q   <= '0;
      pend_mode_q <= LED_OFF;
      pend_duty_q <= '0;
    end else begin
      pend_q      <= pend_d;
      ready_q     <= ready_d;
      pend_ch_q   <= pend_ch_d;
      pend_mode_q <= pend_mode_d;
      pend_duty_q <= pend_duty_d;
    end
  end

  logic [N_CH-1:0] led_d;
  logic [N_CH-1:0] led_q;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    mode_t            mode_q, mode_d;
    logic [PWM_W-1:0] duty_q, duty_d;
    logic [PWM_W-1:0] eff;
    logic             sel;

    // Out-of-range channel numbers match no lane and are simply dropped.
    always_comb begin
      sel    = commit && (pend_ch_q == CH_W'(gi));
      mode_d = sel ? pend_mode_q : mode_q;
      duty_d = sel ? pend_duty_q : duty_q;
      case (mode_q)
        LED_ON:      eff = duty_q;
        LED_BLINK:   eff = blink_phase ? duty_q : '0;
        LED_BREATHE: eff = (ramp < duty_q) ? ramp : duty_q;
        default:     eff = '0;
      endcase
    end

    assign led_d[gi] = (eff == '1) | (pwm_cnt < eff);

    always_ff @(posedge clk) begin
      if (rst) begin
        mode_q <= LED_OFF;
        duty_q <= '0;
      end else begin
        mode_q <= mode_d;
        duty_q <= duty_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) led_q <= '0;
    else     led_q <= led_d;
  end

  assign led        = led_q;
  assign cfg_ready  = ready_q;
  assign frame_tick = tb_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_led_pwm_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_led_pwm_bank : directed self-checking bench for led_pwm_bank        |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module tb_led_pwm_bank;

  localparam int N_CH = 3, PWM_W = 4, PRESC_DIV = 2, BLINK_FRAMES = 2, BREATH_STEP = 1;
  localparam int FRAME_CLK = 32;
  localparam logic [1:0] M_OFF = 2'd0, M_ON = 2'd1, M_BLINK = 2'd2, M_BREATHE = 2'd3;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_ch;
  logic [1:0] cfg_mode;
  logic [3:0] cfg_duty;
  logic [2:0] led;
  logic       frame_tick;

  int n_cmp = 0;
  int n_fail = 0;
  int frame_no = 0;

  always #5 clk = ~clk;

  led_pwm_bank #(
    .N_CH (N_CH), .PWM_W (PWM_W), .PRESC_DIV (PRESC_DIV),
    .BLINK_FRAMES (BLINK_FRAMES), .BREATH_STEP (BREATH_STEP)
  ) dut (
    .clk (clk), .rst (rst),
    .cfg_valid (cfg_valid), .cfg_ready (cfg_ready),
    .cfg_ch (cfg_ch), .cfg_mode (cfg_mode), .cfg_duty (cfg_duty),
    .led (led), .frame_tick (frame_tick)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Frame m (cycles starting at the m-th frame_tick) sees ramp/phase after m frame ends.
  function automatic int tri_ramp(input int m);
    int r;
    r = m % 30;
    return (r <= 15) ? r : 30 - r;
  endfunction

  function automatic int blink_on(input int m);
    return (m / 2) % 2;
  endfunction

  function automatic int on_clks(input int e);
    return (e == 15) ? FRAME_CLK : 2 * e;
  endfunction

  function automatic int min8(input int r);
    return (r < 8) ? r : 8;
  endfunction

  task automatic step();
    @(negedge clk);
    if (!rst && frame_tick) frame_no++;
  endtask

  // Counts led high clocks over one full frame starting at a frame_tick.
  task automatic measure(output int m, output int o0, output int o1, output int o2);
    int n;
    logic early;
    n = 0;
    while (!frame_tick && n < 80) begin
      step();
      n++;
    end
    chk("sync", frame_tick, 1);
    m = frame_no;
    o0 = 0; o1 = 0; o2 = 0;
    early = 1'b0;
    for (int k = 0; k < FRAME_CLK; k++) begin
      step();
      o0 += int'(led[0]);
      o1 += int'(led[1]);
      o2 += int'(led[2]);
      if (k < FRAME_CLK - 1 && frame_tick) early = 1'b1;
    end
    chk($sformatf("period_f%0d", m), {early, frame_tick}, 2'b01);
  endtask

  // Accepts on a frame_tick cycle, so the commit lands one frame later.
  task automatic do_write(input logic [1:0] ch, input logic [1:0] mode, input logic [3:0] duty);
    int n;
    n = 0;
    while (!frame_tick && n < 80) begin
      step();
      n++;
    end
    cfg_valid = 1'b1;
    cfg_ch = ch;
    cfg_mode = mode;
    cfg_duty = duty;
    chk("wr_rdy", cfg_ready, 1);
    step();
    cfg_valid = 1'b0;
    chk("wr_busy", cfg_ready, 0);
    n = 0;
    while (!cfg_ready && n < 80) begin
      step();
      n++;
    end
    chk("wr_lat", n, 32);
  endtask

  initial begin
    int m, o0, o1, o2, n;
    rst = 1'b1;
    cfg_valid = 1'b0;
    cfg_ch = '0;
    cfg_mode = '0;
    cfg_duty = '0;

    repeat (3) step();
    chk("rst_ready", cfg_ready, 0);
    chk("rst_led", led, 0);
    chk("rst_ftick", frame_tick, 0);

    rst = 1'b0;
    frame_no = 0;
    chk("rel_ready0", cfg_ready, 0);
    step();
    chk("rel_ready1", cfg_ready, 1);
    n = 1;
    while (!frame_tick && n < 100) begin
      step();
      n++;
    end
    chk("first_ftick", n, 32);

    measure(m, o0, o1, o2);
    chk("idle_led", {o0, o1, o2} == 0 ? 0 : 1, 0);

    do_write(2'd0, M_ON, 4'd4);
    measure(m, o0, o1, o2);
    chk("on4_ch0", o0, 8);
    chk("on4_ch1", o1, 0);

    do_write(2'd1, M_ON, 4'd15);
    do_write(2'd2, M_ON, 4'd0);
    for (int f = 0; f < 4; f++) begin
      measure(m, o0, o1, o2);
      chk($sformatf("full_ch1_f%0d", m), o1, 32);
      chk($sformatf("zero_ch2_f%0d", m), o2, 0);
      chk($sformatf("on4_ch0_f%0d", m), o0, 8);
    end

    do_write(2'd0, M_BLINK, 4'd15);
    for (int f = 0; f < 4; f++) begin
      measure(m, o0, o1, o2);
      chk($sformatf("blink_ch0_f%0d", m), o0, blink_on(m) * 32);
    end

    do_write(2'd2, M_BREATHE, 4'd8);
    for (int f = 0; f < 32; f++) begin
      measure(m, o0, o1, o2);
      chk($sformatf("breathe_ch2_f%0d", m), o2, on_clks(min8(tri_ramp(m))));
      chk($sformatf("blink2_ch0_f%0d", m), o0, blink_on(m) * 32);
    end

    // Back-to-back writes to ch1: ON 2 then ON 6; the later one must win.
    chk("b2b_rdy", cfg_ready, 1);
    cfg_valid = 1'b1;
    cfg_ch = 2'd1;
    cfg_mode = M_ON;
    cfg_duty = 4'd2;
    step();
    cfg_duty = 4'd6;
    chk("b2b_hold", cfg_ready, 0);
    n = 0;
    while (!cfg_ready && n < 80) begin
      step();
      n++;
    end
    step();
    cfg_valid = 1'b0;
    for (int f = 0; f < 2; f++) begin
      measure(m, o0, o1, o2);
      chk($sformatf("order_ch1_f%0d", m), o1, 12);
    end

    do_write(2'd3, M_ON, 4'd15);
    measure(m, o0, o1, o2);
    chk("badch_ch0", o0, blink_on(m) * 32);
    chk("badch_ch1", o1, 12);
    chk("badch_ch2", o2, on_clks(min8(tri_ramp(m))));

    // Reset while a write is pending: the write must not survive.
    cfg_valid = 1'b1;
    cfg_ch = 2'd1;
    cfg_mode = M_ON;
    cfg_duty = 4'd15;
    chk("rp_rdy", cfg_ready, 1);
    step();
    cfg_valid = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    step();
    chk("rp_ready", cfg_ready, 0);
    chk("rp_led", led, 0);
    rst = 1'b0;
    frame_no = 0;
    for (int f = 0; f < 2; f++) begin
      measure(m, o0, o1, o2);
      chk($sformatf("rp_ch1_f%0d", m), o1, 0);
      chk($sformatf("rp_ch0_f%0d", m), o0 + o2, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
